// File: rtl/miss_bus_if.sv
// Signal bundle between the miss requesters, the arbiter and the shared memory read port.
// The arbiter uses the slave view; cores plus memory (or a bench) use the master view.
interface miss_bus_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES*ADDR_W-1:0] req_addr;
    logic [NUM_CORES-1:0]        done;
    logic [DATA_W-1:0]           blk_data;
    logic                        err;
    logic                        mem_req;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_ack;
    logic                        mem_rvalid;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  req, req_addr, mem_ack, mem_rvalid, mem_rdata,
        output done, blk_data, err, mem_req, mem_addr
    );

    modport master (
        output req, req_addr, mem_ack, mem_rvalid, mem_rdata,
        input  done, blk_data, err, mem_req, mem_addr
    );
endinterface

// File: rtl/miss_bus_arbiter.sv
// Round-robin arbiter sharing one memory read port between NUM_CORES cache-miss requesters,
// with a read timeout and saturating grant/contention counters.
module miss_bus_arbiter #(
    parameter int NUM_CORES       = 4,
    parameter int ADDR_W          = 32,
    parameter int block_size_byte = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    miss_bus_if.slave   bus,
    output logic        busy,
    output logic [15:0] grant_cnt,
    output logic [15:0] stall_cnt
);
    localparam int DATA_W = block_size_byte * 8;
    localparam int PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state, state_n;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     pick;
    logic                 pick_vld;
    logic [NUM_CORES-1:0] req_rot;
    logic [NUM_CORES-1:0] owner_mask;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;
    logic                 to_q;
    logic [15:0]          wait_cnt;
    logic                 stall_now;
    logic                 wait_expired;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Rotate requests so bit 0 is the core at rr_ptr; the lowest set bit then wins.
    assign req_rot = NUM_CORES'({bus.req, bus.req} >> rr_ptr);

    always_comb begin
        int s;
        s        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                s = int'(rr_ptr) + k;
                if (s >= NUM_CORES) s = s - NUM_CORES;
                pick     = PTR_W'(s);
                pick_vld = 1'b1;
            end
        end
    end

    assign owner_mask   = NUM_CORES'(1) << owner;
    assign wait_expired = (wait_cnt == 16'(TIMEOUT));

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (pick_vld) state_n = S_ISSUE;
            S_ISSUE: if (bus.mem_ack) state_n = S_WAIT;
            S_WAIT:  if (bus.mem_rvalid || wait_expired) state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Outputs decode the state register only, so an async reset clears them at once.
    assign busy         = (state != S_IDLE);
    assign bus.mem_req  = (state == S_ISSUE);
    assign bus.mem_addr = addr_q;
    assign bus.done     = (state == S_RESP) ? owner_mask : '0;
    assign bus.blk_data = (state == S_RESP) ? data_q : '0;
    assign bus.err      = (state == S_RESP) && to_q;

    assign stall_now = busy ? |(bus.req & ~owner_mask) : |bus.req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= '0;
            rr_ptr    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            to_q      <= 1'b0;
            wait_cnt  <= '0;
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall_now) stall_cnt <= sat_inc(stall_cnt);
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        owner     <= pick;
                        addr_q    <= bus.req_addr[pick*ADDR_W +: ADDR_W];
                        to_q      <= 1'b0;
                        grant_cnt <= sat_inc(grant_cnt);
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_ack) wait_cnt <= 16'd1;
                end
                S_WAIT: begin
                    // A data beat on the final allowed cycle still counts as a success.
                    if (bus.mem_rvalid) begin
                        data_q <= bus.mem_rdata;
                    end else if (wait_expired) begin
                        data_q <= '0;
                        to_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    rr_ptr <= (owner == PTR_W'(NUM_CORES - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_miss_bus_arbiter.sv
// Bench for miss_bus_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run scored against a transaction-schedule model.
module tb_miss_bus_arbiter;
    localparam int NC = 4;
    localparam int AW = 32;
    localparam int BB = 4;
    localparam int DW = BB * 8;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        busy;
    logic [15:0] grant_cnt;
    logic [15:0] stall_cnt;

    miss_bus_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    miss_bus_arbiter #(
        .NUM_CORES(NC), .ADDR_W(AW), .block_size_byte(BB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .busy(busy), .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 25) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req        = '0;
        bus.req_addr   = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset_n = 1'b0;
        #20 reset_n = 1'b1;
    endtask

    function automatic int idx_of(input logic [NC-1:0] v);
        int r;
        r = -1;
        for (int i = NC - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    typedef struct {
        int          core;
        logic [31:0] addr;
        logic [31:0] data;
        int          ack_dly;   // ISSUE cycles with mem_ack low before the accepting cycle
        int          rv_dly;    // WAIT cycle (1-based) carrying rvalid, 0 = never
        logic [3:0]  exp_done;
        logic [31:0] exp_blk;
        logic        exp_err;
        int          exp_lat;   // cycles from the req cycle to the done cycle
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int row);
        int seen;
        int rv_k;
        seen = 0;
        rv_k = 1 + v.ack_dly + v.rv_dly;
        bus.req_addr[v.core*AW +: AW] = v.addr;
        bus.req[v.core] = 1'b1;
        for (int k = 1; k <= 40 && seen == 0; k++) begin
            tick();
            if (k <= 1 + v.ack_dly) begin
                check($sformatf("vec%0d mem_req", row), bus.mem_req, 1);
                check($sformatf("vec%0d mem_addr", row), bus.mem_addr, v.addr);
            end
            if (bus.done != '0) begin
                seen = 1;
                check($sformatf("vec%0d done", row), bus.done, v.exp_done);
                check($sformatf("vec%0d blk_data", row), bus.blk_data, v.exp_blk);
                check($sformatf("vec%0d err", row), bus.err, v.exp_err);
                check($sformatf("vec%0d latency", row), k, v.exp_lat);
            end else begin
                check($sformatf("vec%0d err idle", row), bus.err, 0);
            end
            bus.req_addr[v.core*AW +: AW] = $urandom & ~32'h3;
            bus.mem_ack    = (k == 1 + v.ack_dly);
            bus.mem_rvalid = (v.rv_dly > 0 && k == rv_k) || (k <= v.ack_dly);
            bus.mem_rdata  = (v.rv_dly > 0 && k == rv_k) ? v.data : $urandom;
        end
        check($sformatf("vec%0d done seen", row), seen, 1);
        bus.req        = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        tick();
        check($sformatf("vec%0d single pulse", row), bus.done, 0);
        tick();
    endtask

    // Randomized-run model: the latest transaction is a set of scheduled cycle numbers.
    bit          txn;
    int          t_g, t_ack, t_w, t_rv, t_resp;
    int          m_owner, m_ptr;
    logic [31:0] m_addr, m_data;
    bit          m_err;
    logic [15:0] m_grants, m_stalls;
    bit          outstanding[NC];

    function automatic bit busy_m(input int n);
        return txn && n >= t_g + 1 && n <= t_resp;
    endfunction

    initial begin
        int          nd, rv_num, steps, da, dr;
        bit          ack_was, found;
        int          order[5];
        int          exp_order[5];
        logic [NC-1:0] rq, exp_done;

        exp_order = '{0, 1, 2, 3, 0};
        vecs[0] = '{2, 32'h0000_0040, 32'hDEAD_BEEF, 0, 1, 4'b0100, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[1] = '{0, 32'h0000_1000, 32'h1234_5678, 2, 3, 4'b0001, 32'h1234_5678, 1'b0, 7};
        vecs[2] = '{3, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1, 8, 4'b1000, 32'hA5A5_A5A5, 1'b0, 11};
        vecs[3] = '{1, 32'h0000_0080, 32'h0BAD_F00D, 0, 0, 4'b0010, 32'h0000_0000, 1'b1, 10};
        vecs[4] = '{1, 32'h0000_0084, 32'hCAFE_F00D, 0, 9, 4'b0010, 32'h0000_0000, 1'b1, 10};
        vecs[5] = '{0, 32'h0000_0008, 32'h0000_0001, 3, 1, 4'b0001, 32'h0000_0001, 1'b0, 6};

        // Reset state
        idle_inputs();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #23;
        check("reset busy", busy, 0);
        check("reset done", bus.done, 0);
        check("reset mem_req", bus.mem_req, 0);
        check("reset mem_addr", bus.mem_addr, 0);
        check("reset blk_data", bus.blk_data, 0);
        check("reset err", bus.err, 0);
        check("reset grant_cnt", grant_cnt, 0);
        check("reset stall_cnt", stall_cnt, 0);
        #4 reset_n = 1'b1;

        // Directed single-core vectors
        tick();
        for (int r = 0; r < 6; r++) run_vec(vecs[r], r);
        check("grant_cnt after table", grant_cnt, 6);

        // All four cores request together: grants go 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NC; i++) bus.req_addr[i*AW +: AW] = 32'h100 * (i + 1);
        bus.req = 4'hF;
        nd = 0;
        rv_num = 0;
        ack_was = 1'b0;
        for (int k = 0; k < 80 && nd < 5; k++) begin
            tick();
            if (bus.done != '0) begin
                check("rr done onehot", $onehot(bus.done), 1);
                check("rr blk_data", bus.blk_data, 32'hD000_0000 + nd);
                order[nd] = idx_of(bus.done);
                if (nd == 3) check("rr grant_cnt after 4", grant_cnt, 4);
                nd++;
            end
            bus.mem_rvalid = ack_was;
            bus.mem_rdata  = 32'hD000_0000 + rv_num;
            if (ack_was) rv_num++;
            bus.mem_ack = bus.mem_req;
            ack_was     = bus.mem_req;
        end
        check("rr dones seen", nd, 5);
        for (int i = 0; i < 5; i++) check($sformatf("rr order[%0d]", i), order[i], exp_order[i]);

        // mem_ack held low: request stays stable, contention counted, then saturates
        do_reset();
        bus.req_addr[1*AW +: AW] = 32'h2220;
        bus.req_addr[3*AW +: AW] = 32'h3330;
        bus.req = 4'b1010;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("hold mem_req", bus.mem_req, 1);
            check("hold mem_addr", bus.mem_addr, 32'h2220);
            check("hold stall_cnt", stall_cnt, k);
            bus.req_addr[1*AW +: AW] = $urandom & ~32'h3;
        end
        steps = 0;
        while (stall_cnt != 16'hFFFE && steps < 70000) begin
            tick();
            steps++;
        end
        check("stall reached FFFE", stall_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall saturated", stall_cnt, 16'hFFFF);
        end
        check("hold grant_cnt", grant_cnt, 1);
        check("hold still issuing", bus.mem_req, 1);

        // Async reset in WAIT aborts; round-robin pointer returns to core 0
        do_reset();
        bus.req_addr[2*AW +: AW] = 32'h4440;
        bus.req = 4'b0100;
        tick(); bus.mem_ack = 1'b1;
        tick(); bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
        tick();
        check("pre-reset done", bus.done, 4'b0100);
        bus.req = '0; bus.mem_rvalid = 1'b0;
        tick();
        bus.req_addr[1*AW +: AW] = 32'h5550;
        bus.req = 4'b0010;
        tick();
        check("second grant addr", bus.mem_addr, 32'h5550);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("in wait busy", busy, 1);
        check("in wait mem_req", bus.mem_req, 0);
        #2 reset_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", bus.done, 0);
        check("abort mem_addr", bus.mem_addr, 0);
        check("abort grant_cnt", grant_cnt, 0);
        check("abort stall_cnt", stall_cnt, 0);
        bus.req = '0;
        #10 reset_n = 1'b1;
        bus.req_addr[0*AW +: AW] = 32'h6660;
        bus.req_addr[3*AW +: AW] = 32'h7770;
        bus.req = 4'b1001;
        tick();
        check("post-reset grant core0", bus.mem_addr, 32'h6660);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0F0F_0F0F;
        tick();
        check("post-reset done", bus.done, 4'b0001);
        check("post-reset blk_data", bus.blk_data, 32'h0F0F_0F0F);
        bus.mem_rvalid = 1'b0;
        bus.req = '0;
        tick();

        // Randomized traffic against the schedule model
        do_reset();
        txn = 1'b0; t_g = 0; t_ack = 0; t_w = 0; t_rv = -1; t_resp = -1;
        m_owner = 0; m_ptr = 0; m_addr = '0; m_data = '0; m_err = 1'b0;
        m_grants = '0; m_stalls = '0;
        for (int i = 0; i < NC; i++) outstanding[i] = 1'b0;
        rq = '0;
        for (int n = 0; n < 3000; n++) begin
            if (n > 0) tick();
            exp_done = (txn && n == t_resp) ? (NC'(1) << m_owner) : '0;
            check($sformatf("rnd busy @%0d", n), busy, busy_m(n));
            check($sformatf("rnd mem_req @%0d", n), bus.mem_req, txn && n >= t_g + 1 && n <= t_ack);
            if (txn && n >= t_g + 1 && n <= t_ack)
                check($sformatf("rnd mem_addr @%0d", n), bus.mem_addr, m_addr);
            check($sformatf("rnd done @%0d", n), bus.done, exp_done);
            check($sformatf("rnd err @%0d", n), bus.err, txn && n == t_resp && m_err);
            if (exp_done != '0) begin
                check($sformatf("rnd blk_data @%0d", n), bus.blk_data, m_data);
                outstanding[m_owner] = 1'b0;
            end
            check($sformatf("rnd grant_cnt @%0d", n), grant_cnt, m_grants);
            check($sformatf("rnd stall_cnt @%0d", n), stall_cnt, m_stalls);

            for (int i = 0; i < NC; i++) begin
                if (outstanding[i]) begin
                    if (busy_m(n) && i == m_owner && rq[i] && ($urandom % 8) == 0) rq[i] = 1'b0;
                end else if (($urandom % 4) == 0) begin
                    rq[i] = 1'b1;
                    outstanding[i] = 1'b1;
                end else begin
                    rq[i] = 1'b0;
                end
                bus.req_addr[i*AW +: AW] = $urandom & ~32'h3;
            end
            bus.req = rq;
            if (txn && n >= t_g + 1 && n <= t_ack) bus.mem_ack = (n == t_ack);
            else bus.mem_ack = (($urandom % 4) == 0);
            if (txn && n >= t_w && n < t_resp) begin
                bus.mem_rvalid = (n == t_rv);
                bus.mem_rdata  = (n == t_rv) ? m_data : $urandom;
            end else begin
                bus.mem_rvalid = (($urandom % 4) == 0);
                bus.mem_rdata  = $urandom;
            end

            if (busy_m(n) ? ((rq & ~(NC'(1) << m_owner)) != '0) : (rq != '0))
                if (m_stalls != 16'hFFFF) m_stalls++;
            if (!busy_m(n) && rq != '0) begin
                found = 1'b0;
                for (int k = 0; k < NC; k++) begin
                    if (!found && rq[(m_ptr + k) % NC]) begin
                        m_owner = (m_ptr + k) % NC;
                        found = 1'b1;
                    end
                end
                m_addr = bus.req_addr[m_owner*AW +: AW];
                if (m_grants != 16'hFFFF) m_grants++;
                da    = $urandom % 4;
                dr    = $urandom_range(1, 10);
                t_g   = n;
                t_ack = n + 1 + da;
                t_w   = t_ack + 1;
                if (dr <= TO) begin
                    t_rv   = t_w + dr - 1;
                    t_resp = t_rv + 1;
                    m_data = $urandom;
                    m_err  = 1'b0;
                end else begin
                    t_rv   = -1;
                    t_resp = t_w + TO;
                    m_data = '0;
                    m_err  = 1'b1;
                end
                m_ptr = (m_owner + 1) % NC;
                txn   = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
